// File: rtl/kyber_pkg.sv
// kyber_pkg: shared constants, FSM state type and input pre-reduction helper
// for the Kyber pointwise-multiply accumulator.
package kyber_pkg;

    localparam int unsigned KYBER_Q   = 3329;
    localparam int unsigned PWM_PAIRS = 128;
    localparam int unsigned COEFF_W   = 12;
    localparam int unsigned IDX_W     = $clog2(PWM_PAIRS);

    localparam logic [15:0]      Q_IN  = 16'(KYBER_Q);
    localparam logic [COEFF_W:0] Q_SUM = (COEFF_W + 1)'(KYBER_Q);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_FLUSH
    } pwm_state_t;

    // Single conditional subtract; inputs up to 2q-1 land in [0, q-1].
    function automatic logic [COEFF_W-1:0] pre_reduce(input logic [15:0] x);
        logic [15:0] t;
        t = (x >= Q_IN) ? (x - Q_IN) : x;
        return COEFF_W'(t);
    endfunction

endpackage

// File: rtl/mod_addsub_q.sv
// mod_addsub_q: one accumulator lane. Registers the pre-reduced product and
// the RAM operand, then combinationally forms the value to write back:
// clear -> x', add -> (acc + x') mod q, sub -> (acc - x') mod q.
module mod_addsub_q
    import kyber_pkg::*;
(
    input  logic               clk,
    input  logic               en,
    input  logic [15:0]        x,
    input  logic [COEFF_W-1:0] acc,
    input  logic               clear,
    input  logic               sub,
    output logic [COEFF_W-1:0] res
);

    logic [COEFF_W-1:0] x_red_q;
    logic [COEFF_W-1:0] acc_q;
    logic [COEFF_W:0]   sum;
    logic [COEFF_W:0]   diff;

    // Pipeline stage: capture reduced input alongside the word read from RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            x_red_q <= pre_reduce(x);
            acc_q   <= acc;
        end
    end

    // Modular combine; both operands are already in [0, q-1].
    always_comb begin
        sum  = {1'b0, acc_q} + {1'b0, x_red_q};
        diff = {1'b0, acc_q} - {1'b0, x_red_q};
        if (clear) begin
            res = x_red_q;
        end else if (sub) begin
            res = (acc_q < x_red_q) ? COEFF_W'(diff + Q_SUM) : COEFF_W'(diff);
        end else begin
            res = (sum >= Q_SUM) ? COEFF_W'(sum - Q_SUM) : COEFF_W'(sum);
        end
    end

endmodule

// File: rtl/pwm_accum.sv
// pwm_accum: accumulates 128 pairs of pointwise-multiply products into a
// 128 x 32-bit RAM, one pass per start pulse, with overwrite or add mode.
// Optional: define PWM_ACCUM_SUB_EN to add the 'sub' port (subtract mode).
module pwm_accum
    import kyber_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        start,
    input  logic        clear_acc,
`ifdef PWM_ACCUM_SUB_EN
    input  logic        sub,
`endif
    input  logic        in_valid,
    input  logic [15:0] in_ra,
    input  logic [15:0] in_rb,
    output logic        busy,
    output logic        pass_done,
    input  logic        rd_en,
    input  logic [6:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_valid
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PWM_PAIRS - 1);
    localparam int unsigned      PAD_W    = 16 - COEFF_W;

    pwm_state_t         state;
    logic [IDX_W-1:0]   idx;
    logic               flush_cnt;
    logic               clr_q;
    logic               sub_q;
    logic               sub_in;
    logic               beat_fire;

    logic               s1_valid;
    logic [IDX_W-1:0]   s1_idx;
    logic [15:0]        s1_ra;
    logic [15:0]        s1_rb;
    logic [COEFF_W-1:0] ram_qa;
    logic [COEFF_W-1:0] ram_qb;
    logic               s2_valid;
    logic [IDX_W-1:0]   s2_idx;
    logic [COEFF_W-1:0] res_a;
    logic [COEFF_W-1:0] res_b;

    logic [COEFF_W-1:0] mem_a [PWM_PAIRS];
    logic [COEFF_W-1:0] mem_b [PWM_PAIRS];

`ifdef PWM_ACCUM_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    assign beat_fire = (state == ST_ACC) && in_valid;

    // Pass control: IDLE -> ACC on start, ACC -> FLUSH on 128th beat,
    // FLUSH holds two cycles so the last write lands before pass_done.
    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            flush_cnt <= 1'b0;
            clr_q     <= 1'b0;
            sub_q     <= 1'b0;
            busy      <= 1'b0;
            pass_done <= 1'b0;
        end else begin
            pass_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ACC;
                        idx   <= '0;
                        clr_q <= clear_acc;
                        sub_q <= sub_in;
                        busy  <= 1'b1;
                    end
                end
                ST_ACC: begin
                    if (in_valid) begin
                        idx <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        pass_done <= 1'b1;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Beat pipeline valid/index/data tracking (stage 0 -> 1 -> 2).
    always_ff @(posedge clk) begin
        if (srst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= beat_fire;
            s2_valid <= s1_valid;
        end
        s2_idx <= s1_idx;
        if (beat_fire) begin
            s1_idx <= idx;
            s1_ra  <= in_ra;
            s1_rb  <= in_rb;
        end
    end

    // Accumulator RAM: read of idx at stage 0, write-back at stage 2.
    // Write is gated by srst so an aborted pass drops in-flight results.
    always_ff @(posedge clk) begin
        ram_qa <= mem_a[idx];
        ram_qb <= mem_b[idx];
        if (s2_valid && !srst) begin
            mem_a[s2_idx] <= res_a;
            mem_b[s2_idx] <= res_b;
        end
    end

    // Host read port, served only while idle; zero data otherwise.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (rd_en && (state == ST_IDLE)) begin
            rd_valid <= 1'b1;
            rd_data  <= {{PAD_W{1'b0}}, mem_a[rd_addr], {PAD_W{1'b0}}, mem_b[rd_addr]};
        end else begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end
    end

    mod_addsub_q u_lane_r0 (
        .clk   (clk),
        .en    (s1_valid),
        .x     (s1_ra),
        .acc   (ram_qa),
        .clear (clr_q),
        .sub   (sub_q),
        .res   (res_a)
    );

    mod_addsub_q u_lane_r1 (
        .clk   (clk),
        .en    (s1_valid),
        .x     (s1_rb),
        .acc   (ram_qb),
        .clear (clr_q),
        .sub   (sub_q),
        .res   (res_b)
    );

endmodule

// File: tb/tb_pwm_accum.sv
// tb_pwm_accum: directed-vector bench for pwm_accum. Reads push expected
// words into a scoreboard queue; a monitor pops and compares on rd_valid.
module tb_pwm_accum;

    logic        clk = 1'b0;
    logic        srst;
    logic        start;
    logic        clear_acc;
`ifdef PWM_ACCUM_SUB_EN
    logic        sub;
`endif
    logic        in_valid;
    logic [15:0] in_ra;
    logic [15:0] in_rb;
    logic        busy;
    logic        pass_done;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;

    int n_cmp = 0;
    int n_err = 0;
    logic [38:0] exp_q [$];

    always #5 clk = ~clk;

    pwm_accum dut (
        .clk       (clk),
        .srst      (srst),
        .start     (start),
        .clear_acc (clear_acc),
`ifdef PWM_ACCUM_SUB_EN
        .sub       (sub),
`endif
        .in_valid  (in_valid),
        .in_ra     (in_ra),
        .in_rb     (in_rb),
        .busy      (busy),
        .pass_done (pass_done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int a, input int b);
        return 32'((a << 16) | b);
    endfunction

    function automatic logic [15:0] gen_ra(input int mode, input int i);
        case (mode)
            0: return 16'(i);
            1: return 16'd3000;
            2: return 16'd1000;
            3: return 16'd3334;
            4: return 16'd7;
            5: return 16'(2 * i);
            6: return 16'd100;
            7: return 16'd200;
            8: return 16'(3329 - 2 * i);
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [15:0] gen_rb(input int mode, input int i);
        case (mode)
            0: return 16'(i + 1);
            1: return 16'd3000;
            2: return 16'd1000;
            3: return 16'd6656;
            4: return 16'd7;
            5: return 16'(3 * i + 100);
            6: return 16'd100;
            7: return 16'd200;
            8: return 16'd6657;
            default: return 16'd0;
        endcase
    endfunction

    // Hand-derived RAM image after the pass of the given mode.
    function automatic logic [31:0] exp_word(input int mode, input int i);
        case (mode)
            0: return pack(i, i + 1);
            2: return pack(671, 671);
            3: return pack(5, 3327);
            5: return pack(2 * i, 3 * i + 100);
            7: return pack(3229, 3229);
            8: return pack(0, 3 * i + 99);
            default: return 32'd0;
        endcase
    endfunction

    // Monitor: every rd_valid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got rd_valid=1 data 0x%08h required no response", rd_data);
            end else begin
                logic [38:0] e;
                e = exp_q.pop_front();
                check($sformatf("rd_data[%0d]", e[38:32]), rd_data, e[31:0]);
            end
        end
    end

    task automatic read_word(input int addr, input logic [31:0] e);
        rd_en   = 1'b1;
        rd_addr = 7'(addr);
        exp_q.push_back({7'(addr), e});
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic read_all(input int mode);
        for (int i = 0; i < 128; i++) read_word(i, exp_word(mode, i));
    endtask

    task automatic run_pass(input bit clr, input bit sb, input int mode, input bit bubbles);
        int k;
        start     = 1'b1;
        clear_acc = clr;
`ifdef PWM_ACCUM_SUB_EN
        sub       = sb;
`else
        if (sb) $display("note: sub requested without PWM_ACCUM_SUB_EN");
`endif
        @(posedge clk); #1;
        start     = 1'b0;
        clear_acc = 1'b0;
`ifdef PWM_ACCUM_SUB_EN
        sub       = 1'b0;
`endif
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 128; i++) begin
            if (bubbles) begin
                while ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
                if (i == 64) begin
                    // Start and read during the pass must both be ignored.
                    in_valid  = 1'b0;
                    start     = 1'b1;
                    clear_acc = 1'b1;
                    rd_en     = 1'b1;
                    rd_addr   = 7'd3;
                    @(posedge clk); #1;
                    start     = 1'b0;
                    clear_acc = 1'b0;
                    rd_en     = 1'b0;
                    check("rd_valid_busy", 32'(rd_valid), 32'd0);
                    check("rd_data_busy", rd_data, 32'd0);
                    check("busy_mid_pass", 32'(busy), 32'd1);
                end
            end
            in_valid = 1'b1;
            in_ra    = gen_ra(mode, i);
            in_rb    = gen_rb(mode, i);
            @(posedge clk); #1;
        end
        // Keep strobing during FLUSH: these beats must not touch RAM.
        in_valid = 1'b1;
        in_ra    = 16'd1000;
        in_rb    = 16'd1000;
        k = 1;
        while (!pass_done && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        check("pass_done_latency", 32'(k), 32'd3);
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pd_seen;
        srst      = 1'b1;
        start     = 1'b0;
        clear_acc = 1'b0;
`ifdef PWM_ACCUM_SUB_EN
        sub       = 1'b0;
`endif
        in_valid  = 1'b0;
        in_ra     = '0;
        in_rb     = '0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pass_done", 32'(pass_done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        srst = 1'b0;
        @(posedge clk); #1;

        // Clear pass i / i+1, no bubbles.
        run_pass(1'b1, 1'b0, 0, 1'b0);
        read_word(5, 32'h0005_0006);
        read_all(0);

        // in_valid while idle must be ignored.
        in_valid = 1'b1;
        in_ra    = 16'd1000;
        in_rb    = 16'd1000;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) read_word(i, exp_word(0, i));

        // Same image with random bubbles and in-pass interference.
        run_pass(1'b1, 1'b0, 0, 1'b1);
        read_all(0);

        // Clear 3000 then add 1000 -> 671.
        run_pass(1'b1, 1'b0, 1, 1'b0);
        run_pass(1'b0, 1'b0, 2, 1'b1);
        read_all(2);

        // Pre-reduction of 3334 / 6656.
        run_pass(1'b1, 1'b0, 3, 1'b0);
        read_word(0, exp_word(3, 0));
        read_word(77, exp_word(3, 77));
        read_word(127, exp_word(3, 127));

        // Abort after 40 beats.
        start     = 1'b1;
        clear_acc = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        clear_acc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_ra    = gen_ra(4, i);
            in_rb    = gen_rb(4, i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        srst     = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pass_done", 32'(pass_done), 32'd0);
        pd_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (pass_done) pd_seen++;
        end
        check("abort_no_pass_done", 32'(pd_seen), 32'd0);

        // Fresh clear pass, then an add pass hitting s == q and x = 2q-1.
        run_pass(1'b1, 1'b0, 5, 1'b0);
        read_all(5);
        run_pass(1'b0, 1'b0, 8, 1'b0);
        read_all(8);

`ifdef PWM_ACCUM_SUB_EN
        run_pass(1'b1, 1'b0, 6, 1'b0);
        run_pass(1'b0, 1'b1, 7, 1'b0);
        read_word(0, exp_word(7, 0));
        read_word(64, exp_word(7, 64));
        read_word(127, exp_word(7, 127));
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
